// File: rtl/tx_serializer_10b.sv
// 10-bit parallel-to-serial stage after the 8b/10b encoder: one-entry holding buffer,
// LSB-first shifting, and K28.5 insertion when starved at a symbol boundary.
module tx_serializer_10b #(
    parameter bit          IDLE_COMMA = 1'b1,
    parameter logic [9:0]  COMMA_NEG  = 10'h17C,
    parameter logic [9:0]  COMMA_POS  = 10'h283,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             rd_in,
    input  logic             tx_en,
    output logic             ser_out,
    output logic             sym_start,
    output logic             comma_sent,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [8:0]         shreg_q, shreg_d;
    logic [9:0]         buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic               s_ready_q, s_ready_d;
    logic               ser_out_q, ser_out_d;
    logic               sym_start_q, sym_start_d;
    logic               comma_sent_q, comma_sent_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    logic               buf_wr;
    logic               boundary;
    logic               load_buf;
    logic               load_comma;
    logic [9:0]         sym;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        ser_out_d    = ser_out_q;
        sym_start_d  = 1'b0;
        comma_sent_d = comma_sent_q;
        word_cnt_d   = word_cnt_q;

        buf_wr     = s_valid && s_ready_q;
        boundary   = (state_q == ST_SHIFT) ? (bit_cnt_q == 4'd9)
                                           : (tx_en && (buf_full_q || IDLE_COMMA));
        load_buf   = boundary && tx_en && buf_full_q;
        load_comma = boundary && tx_en && !buf_full_q && IDLE_COMMA;
        // Load reads the pre-edge buffer, so a same-edge write waits for the next boundary.
        sym        = load_buf ? buf_q : (rd_in ? COMMA_NEG : COMMA_POS);

        if (load_buf || load_comma) begin
            ser_out_d    = sym[0];
            shreg_d      = sym[9:1];
            bit_cnt_d    = 4'd0;
            sym_start_d  = 1'b1;
            comma_sent_d = load_comma;
            state_d      = ST_SHIFT;
            if (load_buf) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
        end else if (boundary || state_q == ST_IDLE) begin
            state_d      = ST_IDLE;
            ser_out_d    = 1'b0;
            comma_sent_d = 1'b0;
            bit_cnt_d    = 4'd0;
        end else begin
            ser_out_d = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        if (load_buf) begin
            buf_full_d = 1'b0;
        end
        if (buf_wr) begin
            buf_d      = s_data;
            buf_full_d = 1'b1;
        end
        s_ready_d = !buf_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 9'd0;
            buf_q        <= 10'd0;
            buf_full_q   <= 1'b0;
            s_ready_q    <= 1'b1;
            ser_out_q    <= 1'b0;
            sym_start_q  <= 1'b0;
            comma_sent_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            s_ready_q    <= s_ready_d;
            ser_out_q    <= ser_out_d;
            sym_start_q  <= sym_start_d;
            comma_sent_q <= comma_sent_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign ser_out    = ser_out_q;
    assign sym_start  = sym_start_q;
    assign comma_sent = comma_sent_q;
    assign busy       = (state_q == ST_SHIFT);
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed bench for tx_serializer_10b: comma insertion/polarity, data streaming,
// idle drop, tx_en drop, async reset mid-symbol, and counter wrap (narrow counter instance).
module tb_tx_serializer_10b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: comma insertion, 16-bit counter
    logic        a_rst_n, a_s_valid, a_rd_in, a_tx_en;
    logic [9:0]  a_s_data;
    logic        a_s_ready, a_ser, a_sym_start, a_comma, a_busy;
    logic [15:0] a_word_cnt;

    // instance B: idle drop, 4-bit counter for wrap
    logic        b_rst_n, b_s_valid, b_rd_in, b_tx_en;
    logic [9:0]  b_s_data;
    logic        b_s_ready, b_ser, b_sym_start, b_comma, b_busy;
    logic [3:0]  b_word_cnt;

    tx_serializer_10b #(.IDLE_COMMA(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .s_data(a_s_data), .s_valid(a_s_valid),
        .s_ready(a_s_ready), .rd_in(a_rd_in), .tx_en(a_tx_en), .ser_out(a_ser),
        .sym_start(a_sym_start), .comma_sent(a_comma), .busy(a_busy), .word_cnt(a_word_cnt)
    );

    tx_serializer_10b #(.IDLE_COMMA(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .s_data(b_s_data), .s_valid(b_s_valid),
        .s_ready(b_s_ready), .rd_in(b_rd_in), .tx_en(b_tx_en), .ser_out(b_ser),
        .sym_start(b_sym_start), .comma_sent(b_comma), .busy(b_busy), .word_cnt(b_word_cnt)
    );

    logic sel_b = 1'b0;
    logic mon_ser, mon_sym_start, mon_comma, mon_ready;
    assign mon_ser       = sel_b ? b_ser       : a_ser;
    assign mon_sym_start = sel_b ? b_sym_start : a_sym_start;
    assign mon_comma     = sel_b ? b_comma     : a_comma;
    assign mon_ready     = sel_b ? b_s_ready   : a_s_ready;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // results of the last captured symbol
    logic [9:0] g_sym;
    int         g_gap;
    int         g_extra_start;
    int         g_comma_bits;
    logic       g_rdy0;

    // Capture one symbol from the selected instance, starting at the negedge where
    // sym_start is seen. act_at/act: side action after sampling a bit
    // (1 = flip a_rd_in, 2 = drop a_tx_en).
    task automatic get_sym(input int act_at, input int act);
        int w;
        g_sym = '0; g_extra_start = 0; g_comma_bits = 0; g_gap = -1; g_rdy0 = 1'b0;
        for (w = 0; w < 40; w++) begin
            @(negedge clk);
            if (mon_sym_start) break;
        end
        if (w == 40) begin
            chk("sym_timeout", 32'd0, 32'd1);
            return;
        end
        g_gap = w;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (mon_sym_start) g_extra_start++;
            end
            else g_rdy0 = mon_ready;
            g_sym[i] = mon_ser;
            if (mon_comma) g_comma_bits++;
            if (i == act_at && act == 1) a_rd_in = ~a_rd_in;
            if (i == act_at && act == 2) a_tx_en = 1'b0;
        end
    endtask

    task automatic push_a(input logic [9:0] d);
        logic rdy;
        a_s_data = d; a_s_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            rdy = a_s_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        a_s_valid = 1'b0;
    endtask

    task automatic push_b(input logic [9:0] d);
        logic rdy;
        b_s_data = d; b_s_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            rdy = b_s_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        b_s_valid = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ser"},   a_ser, 1'b0);
        chk({tag, "_ready"}, a_s_ready, 1'b1);
        chk({tag, "_start"}, a_sym_start, 1'b0);
        chk({tag, "_comma"}, a_comma, 1'b0);
        chk({tag, "_busy"},  a_busy, 1'b0);
        chk({tag, "_cnt"},   a_word_cnt, 16'h0000);
    endtask

    int starts;

    initial begin
        a_rst_n = 1'b0; a_s_valid = 1'b0; a_s_data = '0; a_rd_in = 1'b1; a_tx_en = 1'b0;
        b_rst_n = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_rd_in = 1'b1; b_tx_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_a("rst");

        // ---- comma insertion, RD- then polarity flips mid-symbol ----
        a_rst_n = 1'b1; a_tx_en = 1'b1; a_rd_in = 1'b1;
        get_sym(-1, 0);
        chk("c1_sym", g_sym, 10'h17C);
        chk("c1_gap", g_gap, 0);
        chk("c1_comma", g_comma_bits, 10);
        chk("c1_cnt", a_word_cnt, 0);
        get_sym(4, 1);                       // rd_in -> 0 mid-symbol
        chk("c2_sym", g_sym, 10'h17C);
        chk("c2_gap", g_gap, 0);
        chk("c2_extra", g_extra_start, 0);
        get_sym(4, 1);                       // rd_in -> 1 mid-symbol
        chk("c3_sym", g_sym, 10'h283);
        chk("c3_gap", g_gap, 0);
        chk("c3_comma", g_comma_bits, 10);
        get_sym(-1, 0);
        chk("c4_sym", g_sym, 10'h17C);

        // ---- two words back-to-back, pushed during an in-flight comma ----
        fork
            begin
                push_a(10'h3A5);
                chk("ready_drop", a_s_ready, 1'b0);
                push_a(10'h0F3);
            end
            begin
                get_sym(-1, 0);
                chk("d0_sym", g_sym, 10'h17C);
                get_sym(-1, 0);
                chk("d1_sym", g_sym, 10'h3A5);
                chk("d1_gap", g_gap, 0);
                chk("d1_ready", g_rdy0, 1'b1);
                chk("d1_comma", g_comma_bits, 0);
                get_sym(-1, 0);
                chk("d2_sym", g_sym, 10'h0F3);
                chk("d2_gap", g_gap, 0);
                chk("d2_comma", g_comma_bits, 0);
            end
        join
        chk("d_cnt", a_word_cnt, 16'd2);

        // ---- tx_en dropped at bit 4 of a comma ----
        get_sym(4, 2);
        chk("drop_sym", g_sym, 10'h17C);
        @(negedge clk);
        chk("drop_busy", a_busy, 1'b0);
        chk("drop_ser", a_ser, 1'b0);
        chk("drop_start", a_sym_start, 1'b0);
        chk("drop_comma", a_comma, 1'b0);

        // ---- async reset at bit 6 with a full buffer ----
        push_a(10'h3A5);
        a_tx_en = 1'b1;
        push_a(10'h0F3);
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", a_busy, 1'b1);
        chk("pre_rst_cnt", a_word_cnt, 16'd3);
        chk("pre_rst_ready", a_s_ready, 1'b0);
        a_rst_n = 1'b0;
        #1;
        chk_reset_a("mid_rst");
        @(negedge clk);
        a_rst_n = 1'b1;
        get_sym(-1, 0);
        chk("post_rst_sym", g_sym, 10'h17C);
        chk("post_rst_cnt", a_word_cnt, 16'd0);

        // ---- instance B: no comma insertion ----
        sel_b = 1'b1;
        @(negedge clk);
        b_rst_n = 1'b1; b_tx_en = 1'b1;
        starts = 0;
        repeat (12) begin
            @(negedge clk);
            if (b_sym_start) starts++;
        end
        chk("b_starved_starts", starts, 0);
        chk("b_starved_busy", b_busy, 1'b0);
        chk("b_starved_ser", b_ser, 1'b0);
        push_b(10'h155);
        get_sym(-1, 0);
        chk("b_155_sym", g_sym, 10'h155);
        chk("b_155_comma", g_comma_bits, 0);
        @(negedge clk);
        chk("b_after_busy", b_busy, 1'b0);
        chk("b_after_ser", b_ser, 1'b0);
        chk("b_cnt1", b_word_cnt, 4'd1);

        b_tx_en = 1'b0;
        b_s_data = 10'h3A5; b_s_valid = 1'b1;
        starts = 0;
        repeat (30) begin
            @(negedge clk);
            if (b_sym_start || b_busy) starts++;
        end
        chk("b_hold_starts", starts, 0);
        chk("b_hold_ready", b_s_ready, 1'b0);
        b_s_valid = 1'b0;
        b_tx_en = 1'b1;
        get_sym(-1, 0);
        chk("b_3a5_sym", g_sym, 10'h3A5);
        chk("b_cnt2", b_word_cnt, 4'd2);

        // ---- counter wrap on the narrow instance ----
        for (int n = 0; n < 13; n++) begin
            push_b(10'h0F3);
            get_sym(-1, 0);
        end
        chk("b_cnt15", b_word_cnt, 4'd15);
        push_b(10'h2AA);
        get_sym(-1, 0);
        chk("b_wrap_sym", g_sym, 10'h2AA);
        chk("b_wrap_cnt", b_word_cnt, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
